// File: rtl/morse_char_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : morse_char_scheduler_if
// Description : Key-input and buzzer-handshake bundle for the Morse character
//               scheduler. The master is the scheduler. The slave is the
//               environment: the button front end plus the buzzer driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface morse_char_scheduler_if;
    logic [4:0] key_code;     // character code from the button front end
    logic       key_valid;    // level, high while a key is held
    logic       buzzer_busy;  // driver busy flag
    logic       start;        // one-cycle start pulse to the driver
    logic [4:0] char_out;     // character held stable from start until done

    modport master (
        input  key_code,
        input  key_valid,
        input  buzzer_busy,
        output start,
        output char_out
    );

    modport slave (
        output key_code,
        output key_valid,
        output buzzer_busy,
        input  start,
        input  char_out
    );
endinterface
`default_nettype wire

// File: rtl/morse_char_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : morse_char_scheduler
// Description : Queues key presses in a small FIFO and issues them one at a
//               time to the Morse buzzer driver with a start/busy handshake.
//               A timed silence is enforced after every character.
//               Optional macro MORSE_SCHED_WORD_GAP_EN: code 31 becomes a
//               word-space token that only produces a 7/3-length gap.
// Revision    : 1.0 - initial release
// ============================================================================
module morse_char_scheduler #(
    parameter int CLK_HZ      = 25000000,
    parameter int DEPTH       = 8,
    parameter int GAP_MS      = 300,
    parameter int ACK_TIMEOUT = 15
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    morse_char_scheduler_if.master        bus,
    output logic [$clog2(DEPTH):0]        fifo_count,
    output logic                          overflow,
    output logic                          ack_err,
    output logic                          active
);
    localparam int AW       = $clog2(DEPTH);
    localparam int TICK_DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_LONG = (7 * GAP_MS) / 3;
    localparam int GAP_W    = $clog2(GAP_LONG + 1);
    localparam int ACK_W    = $clog2(ACK_TIMEOUT + 1);
`ifdef MORSE_SCHED_WORD_GAP_EN
    localparam logic [4:0] WORD_TOKEN = 5'd31;
`endif

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_GAP       = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         mem_q [DEPTH];
    logic [4:0]         mem_d [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               key_valid_dly_q, key_valid_dly_d;
    logic               overflow_q, overflow_d;
    logic               ack_err_q, ack_err_d;
    logic               start_q, start_d;
    logic [4:0]         char_q, char_d;
    logic [ACK_W-1:0]   ack_cnt_q, ack_cnt_d;
    logic [PS_W-1:0]    ps_q, ps_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
`ifdef MORSE_SCHED_WORD_GAP_EN
    logic               word_gap_q, word_gap_d;
`endif

    logic               push_req, push, pop, full, tick;
    logic [4:0]         head;
    logic [GAP_W-1:0]   gap_target;

    assign head = mem_q[rd_ptr_q];

    // FIFO bookkeeping: edge-detected push, pop only while loading a character
    always_comb begin
        key_valid_dly_d = bus.key_valid;
        push_req        = bus.key_valid & ~key_valid_dly_q;
        pop             = (state_q == ST_LOAD);
        full            = (count_q == (AW + 1)'(DEPTH));
        // a full FIFO still accepts a press when the head leaves on the same edge
        push            = push_req & (~full | pop);
        mem_d           = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.key_code;
        end
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q | (push_req & ~push);
    end

    // Sequencer next state: load, start, handshake, then timed silence
    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        char_d     = char_q;
        ack_cnt_d  = ack_cnt_q;
        ack_err_d  = ack_err_q;
        ps_d       = ps_q;
        gap_cnt_d  = gap_cnt_q;
        tick       = (ps_q == PS_W'(TICK_DIV - 1));
`ifdef MORSE_SCHED_WORD_GAP_EN
        word_gap_d = word_gap_q;
        gap_target = word_gap_q ? GAP_W'(GAP_LONG - 1) : GAP_W'(GAP_MS - 1);
`else
        gap_target = GAP_W'(GAP_MS - 1);
`endif
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
`ifdef MORSE_SCHED_WORD_GAP_EN
                if (head == WORD_TOKEN) begin
                    word_gap_d = 1'b1;
                    ps_d       = '0;
                    gap_cnt_d  = '0;
                    state_d    = ST_GAP;
                end else
`endif
                begin
                    char_d  = head;
                    start_d = 1'b1;
                    state_d = ST_START;
`ifdef MORSE_SCHED_WORD_GAP_EN
                    word_gap_d = 1'b0;
`endif
                end
            end
            ST_START: begin
                ack_cnt_d = '0;
                state_d   = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (bus.buzzer_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
                    // driver never answered: give up on this character
                    ack_err_d = 1'b1;
                    ps_d      = '0;
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.buzzer_busy) begin
                    ps_d      = '0;
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                ps_d = tick ? '0 : ps_q + 1'b1;
                if (tick) begin
                    if (gap_cnt_q == gap_target) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and status registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            key_valid_dly_q <= 1'b0;
            overflow_q      <= 1'b0;
            ack_err_q       <= 1'b0;
            start_q         <= 1'b0;
            char_q          <= '0;
            ack_cnt_q       <= '0;
            ps_q            <= '0;
            gap_cnt_q       <= '0;
`ifdef MORSE_SCHED_WORD_GAP_EN
            word_gap_q      <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            key_valid_dly_q <= key_valid_dly_d;
            overflow_q      <= overflow_d;
            ack_err_q       <= ack_err_d;
            start_q         <= start_d;
            char_q          <= char_d;
            ack_cnt_q       <= ack_cnt_d;
            ps_q            <= ps_d;
            gap_cnt_q       <= gap_cnt_d;
`ifdef MORSE_SCHED_WORD_GAP_EN
            word_gap_q      <= word_gap_d;
`endif
        end
    end

    // FIFO storage; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.start    = start_q;
    assign bus.char_out = char_q;
    assign fifo_count   = count_q;
    assign overflow     = overflow_q;
    assign ack_err      = ack_err_q;
    assign active       = (state_q != ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_morse_char_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_char_scheduler
// Description : Directed self-checking bench for morse_char_scheduler
//               (CLK_HZ=1000 so one ms tick per cycle, GAP_MS=4, DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_char_scheduler;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] fifo_count;
    logic       overflow, ack_err, active;
    int         checks = 0;
    int         errors = 0;
    int         start_cnt = 0;
    int         busy_viol = 0;

    morse_char_scheduler_if bus ();

    morse_char_scheduler #(
        .CLK_HZ      (1000),
        .DEPTH       (DEPTH),
        .GAP_MS      (4),
        .ACK_TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .ack_err    (ack_err),
        .active     (active)
    );

    always #5 clk = ~clk;

    // count start pulses and flag any start seen while the driver is busy
    always @(negedge clk) begin
        if (rst_n && bus.start) begin
            start_cnt++;
            if (bus.buzzer_busy) busy_viol++;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] code);
        bus.key_code  = code;
        bus.key_valid = 1'b1;
        next_cycle();
        bus.key_valid = 1'b0;
        next_cycle();
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            next_cycle();
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (active === 1'b0) begin
                ok = 1'b1;
                break;
            end
            next_cycle();
        end
    endtask

    // acknowledge the character currently starting, then release the driver
    task automatic finish_char();
        next_cycle();
        bus.buzzer_busy = 1'b1;
        next_cycle();
        next_cycle();
        bus.buzzer_busy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.key_code = '0;
        bus.key_valid = 1'b0;
        bus.buzzer_busy = 1'b0;
        repeat (3) next_cycle();
        checks++; if (bus.start !== 1'b0) begin errors++; $display("FAIL reset_start got %0d exp 0", bus.start); end
        checks++; if (bus.char_out !== 5'd0) begin errors++; $display("FAIL reset_char got %0d exp 0", bus.char_out); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0d exp 0", overflow); end
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL reset_ackerr got %0d exp 0", ack_err); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %0d exp 0", active); end
        rst_n = 1'b1;
        repeat (2) next_cycle();
    endtask

    task automatic test_single_press();
        bus.key_code = 5'd3;
        bus.key_valid = 1'b1;                       // cycle k
        next_cycle();                               // k+1
        bus.key_valid = 1'b0;
        checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL single_count1 got %0d exp 1", fifo_count); end
        next_cycle();                               // k+2 (LOAD)
        checks++; if (bus.start !== 1'b0) begin errors++; $display("FAIL single_early_start got %0d exp 0", bus.start); end
        next_cycle();                               // k+3
        checks++; if (bus.start !== 1'b1) begin errors++; $display("FAIL single_start got %0d exp 1", bus.start); end
        checks++; if (bus.char_out !== 5'd3) begin errors++; $display("FAIL single_char got %0d exp 3", bus.char_out); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL single_count0 got %0d exp 0", fifo_count); end
        next_cycle();                               // k+4
        checks++; if (bus.start !== 1'b0) begin errors++; $display("FAIL single_pulse_len got %0d exp 0", bus.start); end
        bus.buzzer_busy = 1'b1;
        repeat (20) next_cycle();
        bus.buzzer_busy = 1'b0;                     // cycle b
        repeat (4) next_cycle();                    // b+4: last gap cycle
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL single_gap_active got %0d exp 1", active); end
        checks++; if (bus.char_out !== 5'd3) begin errors++; $display("FAIL single_char_hold got %0d exp 3", bus.char_out); end
        next_cycle();                               // b+5
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL single_idle got %0d exp 0", active); end
    endtask

    task automatic test_queueing();
        bit ok;
        int n;
        logic [4:0] exp_c [2];
        exp_c[0] = 5'd2;
        exp_c[1] = 5'd5;
        press(5'd1);
        wait_start(ok);
        checks++; if (!ok || bus.char_out !== 5'd1) begin errors++; $display("FAIL queue_first got %0d exp 1 (ok=%0d)", bus.char_out, ok); end
        next_cycle();
        bus.buzzer_busy = 1'b1;
        press(5'd2);
        checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL queue_count1 got %0d exp 1", fifo_count); end
        press(5'd5);
        checks++; if (fifo_count !== 4'd2) begin errors++; $display("FAIL queue_count2 got %0d exp 2", fifo_count); end
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            bus.buzzer_busy = 1'b0;
            n = 0;
            for (int i = 1; i <= 20; i++) begin
                next_cycle();
                if (bus.start === 1'b1) begin n = i; break; end
            end
            // 4 gap cycles, IDLE, LOAD, then start
            checks++; if (n != 7) begin errors++; $display("FAIL queue_gap%0d got %0d cycles exp 7", c, n); end
            checks++; if (bus.char_out !== exp_c[c]) begin errors++; $display("FAIL queue_order%0d got %0d exp %0d", c, bus.char_out, exp_c[c]); end
            next_cycle();
            bus.buzzer_busy = 1'b1;
        end
        next_cycle();
        bus.buzzer_busy = 1'b0;
        wait_idle(ok);
        checks++; if (!ok || fifo_count !== 4'd0) begin errors++; $display("FAIL queue_drain got %0d exp 0 (ok=%0d)", fifo_count, ok); end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [4:0] exp_c;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre got %0d exp 0", overflow); end
        press(5'd10);
        wait_start(ok);
        checks++; if (!ok || bus.char_out !== 5'd10) begin errors++; $display("FAIL ovf_first got %0d exp 10 (ok=%0d)", bus.char_out, ok); end
        next_cycle();
        bus.buzzer_busy = 1'b1;
        for (int i = 0; i < 9; i++) press(5'(11 + i));
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d exp 8", fifo_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0d exp 1", overflow); end
        bus.buzzer_busy = 1'b0;                     // cycle b
        repeat (6) next_cycle();                    // b+6: LOAD with full FIFO
        bus.key_code = 5'd20;
        bus.key_valid = 1'b1;
        next_cycle();                               // b+7
        bus.key_valid = 1'b0;
        checks++; if (bus.start !== 1'b1 || bus.char_out !== 5'd11) begin errors++; $display("FAIL ovf_pop_start got start=%0d char=%0d exp start=1 char=11", bus.start, bus.char_out); end
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_push_pop_count got %0d exp 8", fifo_count); end
        for (int i = 0; i < 8; i++) begin
            exp_c = (i < 7) ? 5'(12 + i) : 5'd20;
            finish_char();
            wait_start(ok);
            checks++; if (!ok || bus.char_out !== exp_c) begin errors++; $display("FAIL ovf_order%0d got %0d exp %0d (ok=%0d)", i, bus.char_out, exp_c, ok); end
        end
        finish_char();
        wait_idle(ok);
        checks++; if (!ok || fifo_count !== 4'd0) begin errors++; $display("FAIL ovf_drain got %0d exp 0 (ok=%0d)", fifo_count, ok); end
    endtask

    task automatic test_held_key();
        bit ok;
        int snap;
        int tmr;
        snap = start_cnt;
        tmr = 0;
        bus.key_code = 5'd7;
        bus.key_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            next_cycle();
            if (tmr > 0) begin bus.buzzer_busy = 1'b1; tmr--; end
            else bus.buzzer_busy = 1'b0;
            if (bus.start === 1'b1) tmr = 3;
        end
        bus.key_valid = 1'b0;
        bus.buzzer_busy = 1'b0;
        wait_idle(ok);
        repeat (10) next_cycle();
        checks++; if (start_cnt - snap != 1) begin errors++; $display("FAIL held_starts got %0d exp 1", start_cnt - snap); end
        checks++; if (!ok || fifo_count !== 4'd0 || active !== 1'b0) begin errors++; $display("FAIL held_idle got count=%0d active=%0d exp 0 0", fifo_count, active); end
    endtask

    task automatic test_code31();
        bit ok;
        int snap;
        snap = start_cnt;
        press(5'd31);
`ifdef MORSE_SCHED_WORD_GAP_EN
        wait_idle(ok);
        repeat (5) next_cycle();
        checks++; if (!ok || start_cnt != snap) begin errors++; $display("FAIL code31_token got %0d starts exp 0", start_cnt - snap); end
`else
        wait_start(ok);
        checks++; if (!ok || bus.char_out !== 5'd31) begin errors++; $display("FAIL code31_char got %0d exp 31 (ok=%0d snap=%0d)", bus.char_out, ok, snap); end
        finish_char();
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL code31_idle got active=%0d exp 0", active); end
`endif
    endtask

    task automatic test_timeout();
        bit ok;
        checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL to_pre got %0d exp 0", ack_err); end
        press(5'd9);
        wait_start(ok);                             // cycle s
        checks++; if (!ok || bus.char_out !== 5'd9) begin errors++; $display("FAIL to_first got %0d exp 9 (ok=%0d)", bus.char_out, ok); end
        press(5'd4);                                // now s+2
        repeat (13) next_cycle();                   // s+15: last WAIT_ACK cycle
        checks++; if (ack_err !== 1'b0 || active !== 1'b1) begin errors++; $display("FAIL to_early got ack_err=%0d active=%0d exp 0 1", ack_err, active); end
        next_cycle();                               // s+16
        checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL to_flag got %0d exp 1", ack_err); end
        repeat (6) next_cycle();                    // s+22
        checks++; if (bus.start !== 1'b1 || bus.char_out !== 5'd4) begin errors++; $display("FAIL to_next got start=%0d char=%0d exp 1 4", bus.start, bus.char_out); end
        finish_char();
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_idle got active=%0d exp 0", active); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int snap;
        press(5'd1);
        wait_start(ok);
        next_cycle();
        bus.buzzer_busy = 1'b1;
        press(5'd2);
        press(5'd3);
        press(5'd4);
        checks++; if (fifo_count !== 4'd3 || active !== 1'b1) begin errors++; $display("FAIL rmid_pre got count=%0d active=%0d exp 3 1", fifo_count, active); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.start !== 1'b0 || bus.char_out !== 5'd0) begin errors++; $display("FAIL rmid_bus got start=%0d char=%0d exp 0 0", bus.start, bus.char_out); end
        checks++; if (fifo_count !== 4'd0 || active !== 1'b0) begin errors++; $display("FAIL rmid_state got count=%0d active=%0d exp 0 0", fifo_count, active); end
        checks++; if (overflow !== 1'b0 || ack_err !== 1'b0) begin errors++; $display("FAIL rmid_flags got ovf=%0d ack_err=%0d exp 0 0", overflow, ack_err); end
        repeat (2) next_cycle();
        rst_n = 1'b1;
        bus.buzzer_busy = 1'b0;
        snap = start_cnt;
        repeat (30) next_cycle();
        checks++; if (start_cnt != snap || active !== 1'b0) begin errors++; $display("FAIL rmid_quiet got starts=%0d active=%0d exp 0 0", start_cnt - snap, active); end
        press(5'd6);
        wait_start(ok);
        checks++; if (!ok || bus.char_out !== 5'd6) begin errors++; $display("FAIL rmid_new got %0d exp 6 (ok=%0d)", bus.char_out, ok); end
        finish_char();
        wait_idle(ok);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_queueing();
        test_overflow();
        test_held_key();
        test_code31();
        test_timeout();
        test_reset_mid();
        checks++; if (busy_viol != 0) begin errors++; $display("FAIL start_while_busy got %0d exp 0", busy_viol); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
